// File: rtl/zigbee_tx_pkg.sv
// Shared definitions for the Zigbee chip transmitter: PN chip table,
// framing constants, FSM state type and a chip lookup helper.
package zigbee_tx_pkg;

  localparam int CHIPS_PER_SYM = 32;
  localparam int SYMS_PER_BYTE = 2;

  // Bit 31 of each entry is chip c0, the first chip on the wire.
  localparam logic [31:0] PN_TABLE [16] = '{
    32'hD9C3522E, 32'hED9C3522, 32'h2ED9C352, 32'h22ED9C35,
    32'h522ED9C3, 32'h3522ED9C, 32'hC3522ED9, 32'h9C3522ED,
    32'h8C96077B, 32'hB8C96077, 32'h7B8C9607, 32'h77B8C960,
    32'h077B8C96, 32'h6077B8C9, 32'h96077B8C, 32'hC96077B8
  };

  typedef enum logic {IDLE, SEND} tx_state_t;

  function automatic logic pn_chip(input logic [3:0] sym, input logic [4:0] idx);
    logic [31:0] w;
    w = PN_TABLE[sym];
    return w[~idx];
  endfunction

endpackage

// File: rtl/zigbee_chip_tx_rate_gen.sv
// Chip period counter: counts 0..P-1 and flags the first and last cycle
// of each chip. A restart forces the next cycle to be a chip's first.
module chip_rate_gen #(
  parameter int NB_P_W = 6
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NB_P_W-1:0] i_period,
  input  logic              i_restart,
  output logic              o_chip_en,
  output logic              o_chip_last
);

  logic [NB_P_W-1:0] cnt_q, cnt_d;

  always_comb begin
    o_chip_en   = (cnt_q == '0);
    o_chip_last = (cnt_q == i_period - NB_P_W'(1));
    cnt_d       = (i_restart || o_chip_last) ? '0 : cnt_q + NB_P_W'(1);
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/zigbee_chip_tx.sv
// Zigbee transmit chip serializer: byte handshake with one holding slot,
// nibble-to-PN mapping and serial chip output at a programmable period.
module zigbee_chip_tx
  import zigbee_tx_pkg::*;
#(
  parameter int NB_P_W = 6,
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NB_P_W-1:0] i_nb_P,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic              o_dir,
  output logic              o_chip_en,
  output logic              o_busy
);

  tx_state_t         state_q;
  logic [DATA_W-1:0] hold_q, act_q;
  logic              hold_full_q;
  logic [NB_P_W-1:0] period_q;
  logic [4:0]        chip_idx_q;
  logic              nib_q, dir_q, busy_q;

  logic              gen_chip_en, chip_last;
  logic              accept, byte_end, reload;
  logic [NB_P_W-1:0] p_clamped;
  logic [4:0]        next_idx;
  logic              next_nib;
  logic [3:0]        next_sym;

  always_comb begin
    accept    = i_valid && !hold_full_q;
    byte_end  = (state_q == SEND) && chip_last &&
                (chip_idx_q == 5'(CHIPS_PER_SYM - 1)) &&
                (nib_q == 1'(SYMS_PER_BYTE - 1));
    reload    = hold_full_q && ((state_q == IDLE) || byte_end);
    p_clamped = (i_nb_P < NB_P_W'(2)) ? NB_P_W'(2) : i_nb_P;
    next_idx  = chip_idx_q + 5'd1;
    next_nib  = nib_q ^ (chip_idx_q == 5'(CHIPS_PER_SYM - 1));
    next_sym  = next_nib ? act_q[7:4] : act_q[3:0];
  end

  chip_rate_gen #(.NB_P_W(NB_P_W)) u_rate (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_period   (period_q),
    .i_restart  (reload),
    .o_chip_en  (gen_chip_en),
    .o_chip_last(chip_last)
  );

  // Accept and reload never coincide: reload needs hold_full, accept needs it clear.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      act_q       <= '0;
      period_q    <= '0;
      chip_idx_q  <= '0;
      nib_q       <= 1'b0;
      dir_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      if (accept) begin
        hold_q      <= i_data;
        hold_full_q <= 1'b1;
      end else if (reload) begin
        hold_full_q <= 1'b0;
      end

      if (reload) begin
        act_q      <= hold_q;
        period_q   <= p_clamped;
        chip_idx_q <= '0;
        nib_q      <= 1'b0;
        dir_q      <= pn_chip(hold_q[3:0], 5'd0);
        busy_q     <= 1'b1;
        state_q    <= SEND;
      end else if ((state_q == IDLE) || byte_end) begin
        state_q <= IDLE;
        dir_q   <= 1'b0;
        busy_q  <= 1'b0;
      end else if (chip_last) begin
        chip_idx_q <= next_idx;
        nib_q      <= next_nib;
        dir_q      <= pn_chip(next_sym, next_idx);
      end
    end
  end

  assign o_ready   = !hold_full_q;
  assign o_dir     = dir_q;
  assign o_busy    = busy_q;
  assign o_chip_en = busy_q & gen_chip_en;

endmodule
